// File: rtl/fork_join_sched_pkg.sv
// Shared types for the fork/join scheduler: join modes, FSM states, mode width.
package fork_join_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    JOIN_ALL      = 2'd0,
    JOIN_ANY      = 2'd1,
    JOIN_NONE     = 2'd2,
    JOIN_ANY_KILL = 2'd3
  } join_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    POST  = 2'd2,
    DRAIN = 2'd3
  } fj_state_t;

endpackage

// File: rtl/fork_join_sched_if.sv
// Launch/status bundle of the fork/join scheduler; the scheduler takes the slave side.
interface fork_join_sched_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 8,
  parameter int T_W   = 16
);
  import fork_join_pkg::*;

  logic                    start;
  logic [MODE_W-1:0]       mode;
  logic [N_CH*CNT_W-1:0]   ch_delay;
  logic [CNT_W-1:0]        post_delay;
  logic                    busy;
  logic [N_CH-1:0]         ch_active;
  logic [N_CH-1:0]         ch_done;
  logic                    joined;
  logic                    post_done;
  logic                    done;
  logic [T_W-1:0]          elapsed;

  modport master (
    output start, mode, ch_delay, post_delay,
    input  busy, ch_active, ch_done, joined, post_done, done, elapsed
  );

  modport slave (
    input  start, mode, ch_delay, post_delay,
    output busy, ch_active, ch_done, joined, post_done, done, elapsed
  );

endinterface

// File: rtl/fork_join_sched_countdown.sv
// Loadable countdown standing in for a delayed task body; done_pulse marks its last
// counting cycle, and a zero load counts as one cycle.
module fj_countdown #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             kill,
  output logic             active,
  output logic             done_pulse
);

  logic [CNT_W-1:0] cnt;
  logic             act_q;
  logic             last;

  assign last       = act_q && (cnt == CNT_W'(1));
  assign active     = act_q;
  assign done_pulse = last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
    end else if (load) begin
      act_q <= 1'b1;
    end else if (kill || last) begin
      act_q <= 1'b0;
    end
  end

  // Count value carries no reset; it is only observed through act_q.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= (value == '0) ? CNT_W'(1) : value;
    end else if (act_q && !last) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fork_join_sched.sv
// Fork/join scheduler: forks N_CH countdown channels, joins per the latched mode,
// runs a post countdown, then drains remaining channels before signalling done.
module fork_join_sched
  import fork_join_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int CNT_W = 8,
  parameter int T_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fork_join_sched_if.slave bus
);

  fj_state_t        state, state_nxt;
  join_mode_t       mode_q;
  logic [CNT_W-1:0] post_q;
  logic [T_W-1:0]   elapsed_q;
  logic [N_CH-1:0]  ch_act, ch_dn;
  logic             post_act, post_dn;
  logic             accept, all_clear, joined, done_c, kill;

  assign accept = (state == IDLE) && bus.start;
  // True when no channel will still be counting after this cycle.
  assign all_clear = &(~ch_act | ch_dn);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    fj_countdown #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept),
      .value      (bus.ch_delay[i*CNT_W +: CNT_W]),
      .kill       (kill),
      .active     (ch_act[i]),
      .done_pulse (ch_dn[i])
    );
  end

  fj_countdown #(.CNT_W(CNT_W)) u_post (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (joined),
    .value      (post_q),
    .kill       (1'b0),
    .active     (post_act),
    .done_pulse (post_dn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (joined) state_nxt = POST;
      POST:    if (post_dn) state_nxt = all_clear ? IDLE : DRAIN;
      DRAIN:   if (all_clear) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    joined = 1'b0;
    done_c = 1'b0;
    case (state)
      RUN: begin
        case (mode_q)
          JOIN_ALL:      joined = all_clear;
          JOIN_ANY:      joined = |ch_dn;
          JOIN_NONE:     joined = 1'b1;
          JOIN_ANY_KILL: joined = |ch_dn;
          default:       joined = 1'b0;
        endcase
      end
      POST:    done_c = post_dn && all_clear;
      DRAIN:   done_c = all_clear;
      default: begin
        joined = 1'b0;
        done_c = 1'b0;
      end
    endcase
  end

  assign kill = joined && (mode_q == JOIN_ANY_KILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= JOIN_ALL;
    end else if (accept) begin
      mode_q <= join_mode_t'(bus.mode);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      post_q <= bus.post_delay;
    end
  end

  // The accept edge counts as the first elapsed cycle, so elapsed reads k at cycle T+k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elapsed_q <= '0;
    end else if (accept) begin
      elapsed_q <= T_W'(1);
    end else if ((state != IDLE) && !done_c && (elapsed_q != '1)) begin
      elapsed_q <= elapsed_q + T_W'(1);
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.ch_active = ch_act;
  assign bus.ch_done   = ch_dn;
  assign bus.joined    = joined;
  assign bus.post_done = post_dn;
  assign bus.done      = done_c;
  assign bus.elapsed   = elapsed_q;

  logic unused_post_act;
  assign unused_post_act = post_act;

endmodule

// File: tb/tb_fork_join_sched.sv
// Bench for fork_join_sched: timing model built from the join/post/drain rules,
// cycle-by-cycle compare, directed literal pins, and randomized launches.
module tb_fork_join_sched;
  import fork_join_pkg::*;

  localparam int N = 3;
  localparam int CW = 8;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fork_join_sched_if #(.N_CH(N), .CNT_W(CW), .T_W(TW)) bus ();

  fork_join_sched #(.N_CH(N), .CNT_W(CW), .T_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: k = cycle index relative to the accept edge (cycle T+k).
  bit launched = 1'b0;
  int k = 0;
  int m_mode, m_J, m_D;
  int m_d[N];
  bit m_kl[N];
  int m_p;

  int rec_chd[N], rec_clr[N];
  int rec_join, rec_post, rec_done;

  function automatic bit m_busy();
    return launched && (k >= 1) && (k <= m_D);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      launched = 1'b0;
      k = 0;
    end else begin
      if (bus.start && !m_busy()) begin
        m_mode = int'(bus.mode);
        for (int i = 0; i < N; i++) begin
          m_d[i] = int'(bus.ch_delay[i*CW +: CW]);
          if (m_d[i] == 0) m_d[i] = 1;
        end
        m_p = int'(bus.post_delay);
        if (m_p == 0) m_p = 1;
        case (m_mode)
          0: begin m_J = 0; for (int i = 0; i < N; i++) if (m_d[i] > m_J) m_J = m_d[i]; end
          2: m_J = 1;
          default: begin m_J = 1 << 30; for (int i = 0; i < N; i++) if (m_d[i] < m_J) m_J = m_d[i]; end
        endcase
        m_D = m_J + m_p;
        for (int i = 0; i < N; i++) begin
          m_kl[i] = (m_mode == 3) && (m_d[i] > m_J);
          if (!m_kl[i] && m_d[i] > m_D) m_D = m_d[i];
        end
        for (int i = 0; i < N; i++) begin rec_chd[i] = -1; rec_clr[i] = -1; end
        rec_join = -1; rec_post = -1; rec_done = -1;
        launched = 1'b1;
        k = 1;
      end else if (launched && k < 1000000) begin
        k++;
      end
    end
  end

  always @(negedge clk) begin
    int e_act, e_dn, e_el;
    bit e_j, e_pd, e_dd, e_b;
    e_act = 0; e_dn = 0; e_j = 0; e_pd = 0; e_dd = 0; e_b = 0; e_el = 0;
    if (launched) begin
      for (int i = 0; i < N; i++) begin
        if (k >= 1 && k <= m_d[i] && !(m_kl[i] && k > m_J)) e_act |= (1 << i);
        if (k == m_d[i] && !m_kl[i]) e_dn |= (1 << i);
      end
      e_j  = (k == m_J);
      e_pd = (k == m_J + m_p);
      e_dd = (k == m_D);
      e_b  = (k >= 1) && (k <= m_D);
      e_el = (k <= m_D) ? k : m_D;
      if (e_el > (1 << TW) - 1) e_el = (1 << TW) - 1;
      for (int i = 0; i < N; i++) begin
        if (bus.ch_done[i] && rec_chd[i] < 0) rec_chd[i] = k;
        if (!bus.ch_active[i] && rec_clr[i] < 0) rec_clr[i] = k;
      end
      if (bus.joined && rec_join < 0) rec_join = k;
      if (bus.post_done && rec_post < 0) rec_post = k;
      if (bus.done && rec_done < 0) rec_done = k;
    end
    chk("busy", int'(bus.busy), int'(e_b));
    chk("ch_active", int'(bus.ch_active), e_act);
    chk("ch_done", int'(bus.ch_done), e_dn);
    chk("joined", int'(bus.joined), int'(e_j));
    chk("post_done", int'(bus.post_done), int'(e_pd));
    chk("done", int'(bus.done), int'(e_dd));
    chk("elapsed", int'(bus.elapsed), e_el);
  end

  task automatic launch(input int md, input int d0, input int d1, input int d2, input int p);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = md[1:0];
    bus.ch_delay = {d2[7:0], d1[7:0], d0[7:0]};
    bus.post_delay = p[7:0];
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (launched && k > m_D) ok = 1'b1;
    end
    chk({tag, "_finished"}, int'(ok), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.mode = '0;
    bus.ch_delay = '0;
    bus.post_delay = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_elapsed", int'(bus.elapsed), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    launch(1, 5, 10, 15, 5);
    wait_idle("any");
    chk("any_chd0", rec_chd[0], 5);
    chk("any_chd1", rec_chd[1], 10);
    chk("any_chd2", rec_chd[2], 15);
    chk("any_join", rec_join, 5);
    chk("any_post", rec_post, 10);
    chk("any_done", rec_done, 15);
    chk("any_elapsed", int'(bus.elapsed), 15);

    launch(0, 5, 10, 15, 5);
    wait_idle("all");
    chk("all_join", rec_join, 15);
    chk("all_post", rec_post, 20);
    chk("all_done", rec_done, 20);

    launch(3, 5, 10, 15, 5);
    wait_idle("kill");
    chk("kill_chd0", rec_chd[0], 5);
    chk("kill_chd1", rec_chd[1], -1);
    chk("kill_chd2", rec_chd[2], -1);
    chk("kill_clr1", rec_clr[1], 6);
    chk("kill_clr2", rec_clr[2], 6);
    chk("kill_done", rec_done, 10);

    launch(2, 3, 3, 3, 0);
    wait_idle("none");
    chk("none_join", rec_join, 1);
    chk("none_post", rec_post, 2);
    chk("none_chd", rec_chd[0] + rec_chd[1] + rec_chd[2], 9);
    chk("none_done", rec_done, 3);

    launch(2, 0, 0, 0, 0);
    wait_idle("zero");
    chk("zero_chd0", rec_chd[0], 1);
    chk("zero_done", rec_done, 2);

    // Second start two cycles into a launch must be ignored.
    launch(0, 5, 10, 15, 5);
    bus.start = 1'b1;
    bus.mode = 2'd2;
    bus.ch_delay = {8'd1, 8'd1, 8'd1};
    bus.post_delay = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("busy_start");
    chk("busy_join", rec_join, 15);
    chk("busy_done", rec_done, 20);

    // Reset asserted while the post task is running.
    launch(0, 5, 10, 15, 5);
    while (!(launched && k == 17)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstpost_busy", int'(bus.busy), 0);
    chk("rstpost_active", int'(bus.ch_active), 0);
    chk("rstpost_elapsed", int'(bus.elapsed), 0);
    chk("rstpost_pd", int'(bus.post_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    launch(1, 2, 3, 4, 1);
    wait_idle("after_rst");
    chk("after_rst_join", rec_join, 2);
    chk("after_rst_done", rec_done, 4);

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 5) == 0);
      bus.mode = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) bus.ch_delay[i*CW +: CW] = 8'($urandom_range(0, 20));
      bus.post_delay = 8'($urandom_range(0, 20));
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fork_join_sched.md
# fork_join_sched

Synthesizable fork/join scheduler that launches `N_CH` timed channel tasks together and fires a follow-on post task when a selectable join condition is met. Each channel is a programmable countdown that stands in for a delayed task body. The block is the hardware counterpart of the team's fork/join test sequences and is used as a sequencing and barrier primitive in stimulus and control paths. It adds join-all, join-any, join-none and join-any-with-kill modes, per-channel delays and an elapsed-time counter.

## Interface
- `N_CH`, default 3: number of forked channels, 1..16.
- `CNT_W`, default 8: width of each delay value.
- `T_W`, default 16: width of the elapsed-time counter.

- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; accepted only while `busy`=0.
- `mode`  in  2  join mode, sampled at accept: 0 ALL, 1 ANY, 2 NONE, 3 ANY_KILL.
- `ch_delay`  in  N_CH*CNT_W  per-channel delay, channel i in bits [i*CNT_W +: CNT_W], sampled at accept.
- `post_delay`  in  CNT_W  post-task delay, sampled at accept.
- `busy`  out  1  high while a launch is in progress.
- `ch_active`  out  N_CH  channel i still counting.
- `ch_done`  out  N_CH  one-cycle pulse when channel i completes.
- `joined`  out  1  one-cycle pulse when the join condition is met.
- `post_done`  out  1  one-cycle pulse when the post task completes.
- `done`  out  1  one-cycle pulse when all work for the launch has finished.
- `elapsed`  out  T_W  cycles since accept; saturates at all-ones.

## Operation
- States: IDLE → RUN → POST → DRAIN → IDLE.
- **IDLE:** `start`=1 at edge T is an accept. On accept: latch mode and delays, load all channel counters, clear `elapsed`, go to RUN.
- **Delays:** a delay value of 0 is treated as 1.
- **Join condition in RUN:**
  - ALL: every channel has completed.
  - ANY / ANY_KILL: first completion; several channels completing in the same cycle is one join.
  - NONE: cycle T+1.
- **On join:** pulse `joined`, load the post counter, go to POST.
- **ANY_KILL:** on join, every still-active channel is cancelled. Its `ch_active` clears and it never pulses `ch_done`.
- **POST:** channels that are not killed keep counting. When `post_done` fires, go to DRAIN.
- **DRAIN:** when no channels are active, pulse `done` and go to IDLE. `done` fires in the same cycle as the last of `post_done` and the final `ch_done`, so DRAIN may last zero cycles.
- **`start` while `busy`=1:** ignored with no effect, including in the `done` cycle.
- **`elapsed`:** increments by 1 each cycle while `busy`, holds its value after `done`, saturates at 2^T_W−1.

## Timing
- Accept at edge T: `busy` and `ch_active` go high at T+1. `elapsed` = k at cycle T+k.
- `ch_done[i]` pulses at cycle T+d_i.
- `joined` pulses at:
  - ALL: T+max(d).
  - ANY / ANY_KILL: T+min(d).
  - NONE: T+1.
- With `joined` at cycle J, `post_done` pulses at J+p (p = post delay).
- `done` pulses at max(J+p, last `ch_done`). `busy` falls in the cycle after `done`.
- Reset: all outputs are 0 and state is IDLE, asynchronously on `rst_n` low. Asserting reset mid-launch aborts it with no further pulses. Release is synchronous to the next edge.

## Structure
- Package `fork_join_pkg` holds:
  - the `join_mode_t` enum (JOIN_ALL, JOIN_ANY, JOIN_NONE, JOIN_ANY_KILL);
  - the `fj_state_t` enum (IDLE, RUN, POST, DRAIN);
  - the mode width constant.
- Sub-module `fj_countdown`:
  - parameter `CNT_W`; ports `clk`, `rst_n`, `load`, `value`, `kill`, `active`, `done_pulse`;
  - zero-to-one clamping is done inside this sub-module;
  - instantiated N_CH+1 times: N_CH channels plus the post counter.
- Top level holds the FSM, join logic and `elapsed`.

## Test plan
- ANY, delays 5/10/15, post 5, start at T:
  - `ch_done` at T+5, T+10, T+15;
  - `joined` at T+5, `post_done` at T+10, `done` at T+15, `elapsed`=15 after done.
- ALL, delays 5/10/15, post 5: `joined` at T+15, `post_done` and `done` at T+20.
- ANY_KILL, delays 5/10/15, post 5:
  - `ch_done[0]` only, at T+5;
  - `ch_active[2:1]` clear at T+6;
  - `done` at T+10.
- NONE, delays 3/3/3, post 0: `joined` T+1, `post_done` T+2, all `ch_done` T+3, `done` T+3.
- Start while busy: second `start` at T+2 is ignored, and the first launch timing is unchanged.
- Reset during POST: all outputs 0 immediately; no pulses after release; a new start accepted normally.
